// File: rtl/code_game_pkg.sv
// Shared types and constants for the code-breaking game.
// LFSR is the right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
package code_game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTER = 3'd1,
    CHECK = 3'd2,
    WON   = 3'd3,
    LOST  = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Tap mask over the current register: bits 0, 2, 3 and 5 feed bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int DEF_CODE_DIGITS = 4;
  localparam int DEF_DIGIT_W     = 4;
  localparam int DEF_MAX_TRIES   = 8;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one push-button level.
// pulse is high for one clk in the cycle after the second sync stage goes high.
module btn_sync_edge (
  input  logic clk,
  input  logic resetb,
  input  logic btn_in,
  output logic pulse
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn_in};
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // sync_q[2] only serves as the previous value of the synchronized level.
  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/code_entry_fsm.sv
// Code-breaking game: LFSR-drawn secret, digit-by-digit entry, one-cycle guess check.
// Define CODE_HINT_EN to build the registered per-digit match mask on hint.
module code_entry_fsm
  import code_game_pkg::*;
#(
  parameter int CODE_DIGITS = DEF_CODE_DIGITS,
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int MAX_TRIES   = DEF_MAX_TRIES
) (
  input  logic                               clk,
  input  logic                               resetb,
  input  logic                               start_btn,
  input  logic                               enter_btn,
  input  logic [DIGIT_W-1:0]                 guess_digit,
  output logic                               startgame,
  output logic                               breakcode,
  output logic                               gameover,
  output logic [$clog2(MAX_TRIES+1)-1:0]     attempts,
  output logic [$clog2(CODE_DIGITS)-1:0]     digit_ptr,
  output logic [CODE_DIGITS-1:0]             hint
);

  localparam int SECRET_W = CODE_DIGITS * DIGIT_W;
  localparam int ATT_W    = $clog2(MAX_TRIES + 1);
  localparam int PTR_W    = $clog2(CODE_DIGITS);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CODE_DIGITS - 1);
  localparam logic [ATT_W-1:0] MAX_ATT  = ATT_W'(MAX_TRIES);

  logic start_pls;
  logic enter_pls;

  btn_sync_edge u_start_sync (
    .clk    (clk),
    .resetb (resetb),
    .btn_in (start_btn),
    .pulse  (start_pls)
  );

  btn_sync_edge u_enter_sync (
    .clk    (clk),
    .resetb (resetb),
    .btn_in (enter_btn),
    .pulse  (enter_pls)
  );

  state_e              state_q,     state_d;
  logic [15:0]         lfsr_q,      lfsr_d;
  logic [SECRET_W-1:0] secret_q,    secret_d;
  logic [SECRET_W-1:0] guess_q,     guess_d;
  logic [ATT_W-1:0]    attempts_q,  attempts_d;
  logic [PTR_W-1:0]    digit_ptr_q, digit_ptr_d;
  logic                startgame_q, startgame_d;
  logic                breakcode_q, breakcode_d;
  logic                gameover_q,  gameover_d;

  logic code_hit;
  assign code_hit = (guess_q == secret_q);

`ifdef CODE_HINT_EN
  logic [CODE_DIGITS-1:0] hint_q, hint_d, hint_mask;

  always_comb begin
    hint_mask = '0;
    for (int i = 0; i < CODE_DIGITS; i++) begin
      hint_mask[i] = (guess_q[i*DIGIT_W +: DIGIT_W] == secret_q[i*DIGIT_W +: DIGIT_W]);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_next(lfsr_q);
    secret_d    = secret_q;
    guess_d     = guess_q;
    attempts_d  = attempts_q;
    digit_ptr_d = digit_ptr_q;
`ifdef CODE_HINT_EN
    hint_d      = hint_q;
`endif

    // Start wins over a coincident enter and restarts from any state.
    if (start_pls) begin
      secret_d    = SECRET_W'(lfsr_q);
      attempts_d  = '0;
      digit_ptr_d = '0;
`ifdef CODE_HINT_EN
      hint_d      = '0;
`endif
      state_d     = ENTER;
    end else begin
      case (state_q)
        ENTER: begin
          if (enter_pls) begin
            guess_d[int'(digit_ptr_q)*DIGIT_W +: DIGIT_W] = guess_digit;
            if (digit_ptr_q == LAST_PTR) begin
              digit_ptr_d = '0;
              state_d     = CHECK;
            end else begin
              digit_ptr_d = digit_ptr_q + PTR_W'(1);
            end
          end
        end
        CHECK: begin
          if (attempts_q < MAX_ATT) begin
            attempts_d = attempts_q + ATT_W'(1);
          end
`ifdef CODE_HINT_EN
          hint_d = hint_mask;
`endif
          if (code_hit) begin
            state_d = WON;
          end else if (attempts_d == MAX_ATT) begin
            state_d = LOST;
          end else begin
            state_d = ENTER;
          end
        end
        default: begin
        end
      endcase
    end

    startgame_d = (state_d != IDLE);
    breakcode_d = (state_d == WON);
    gameover_d  = (state_d == LOST);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      secret_q    <= '0;
      guess_q     <= '0;
      attempts_q  <= '0;
      digit_ptr_q <= '0;
      startgame_q <= 1'b0;
      breakcode_q <= 1'b0;
      gameover_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      secret_q    <= secret_d;
      guess_q     <= guess_d;
      attempts_q  <= attempts_d;
      digit_ptr_q <= digit_ptr_d;
      startgame_q <= startgame_d;
      breakcode_q <= breakcode_d;
      gameover_q  <= gameover_d;
    end
  end

`ifdef CODE_HINT_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      hint_q <= '0;
    end else begin
      hint_q <= hint_d;
    end
  end

  assign hint = hint_q;
`else
  assign hint = '0;
`endif

  assign startgame = startgame_q;
  assign breakcode = breakcode_q;
  assign gameover  = gameover_q;
  assign attempts  = attempts_q;
  assign digit_ptr = digit_ptr_q;

endmodule

// File: tb/tb_code_entry_fsm.sv
// Self-checking bench for code_entry_fsm: game-level reference model with an LFSR sequence model.
module tb_code_entry_fsm;

  localparam int CD = 4;
  localparam int DW = 4;
  localparam int MT = 8;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          start_btn = 1'b0;
  logic          enter_btn = 1'b0;
  logic [DW-1:0] guess_digit = '0;
  logic          startgame, breakcode, gameover;
  logic [3:0]    attempts;
  logic [1:0]    digit_ptr;
  logic [CD-1:0] dut_hint;

  code_entry_fsm #(.CODE_DIGITS(CD), .DIGIT_W(DW), .MAX_TRIES(MT)) dut (
    .clk         (clk),
    .resetb      (resetb),
    .start_btn   (start_btn),
    .enter_btn   (enter_btn),
    .guess_digit (guess_digit),
    .startgame   (startgame),
    .breakcode   (breakcode),
    .gameover    (gameover),
    .attempts    (attempts),
    .digit_ptr   (digit_ptr),
    .hint        (dut_hint)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: LFSR sequence plus game progress in plain integers.
  logic [15:0] lfsr_m = 16'hACE1;
  logic [15:0] secret_m = '0;
  logic [15:0] guess_m = '0;
  bit          in_game = 0;
  bit          m_won = 0;
  bit          m_lost = 0;
  int          m_att = 0;
  int          m_ptr = 0;
  logic [3:0]  m_hint = '0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
    return (l >> 1) | (b << 15);
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] v, input int i);
    logic [15:0] s;
    s = (v >> (4 * i)) & 16'h000F;
    return s[3:0];
  endfunction

  task automatic check(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] exp_hint;
`ifdef CODE_HINT_EN
    exp_hint = m_hint;
`else
    exp_hint = 4'b0000;
`endif
    check(tag, "startgame", 32'(startgame), 32'(in_game));
    check(tag, "breakcode", 32'(breakcode), 32'(m_won));
    check(tag, "gameover",  32'(gameover),  32'(m_lost));
    check(tag, "attempts",  32'(attempts),  32'(m_att));
    check(tag, "digit_ptr", 32'(digit_ptr), 32'(m_ptr));
    check(tag, "hint",      32'(dut_hint),  32'(exp_hint));
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetb) lfsr_m = lfsr_step(lfsr_m);
    #1;
  endtask

  task automatic model_reset();
    lfsr_m  = 16'hACE1;
    in_game = 0;
    m_won   = 0;
    m_lost  = 0;
    m_att   = 0;
    m_ptr   = 0;
    m_hint  = '0;
  endtask

  task automatic model_guess_done();
    m_ptr = 0;
    if (m_att < MT) m_att++;
    for (int i = 0; i < CD; i++) m_hint[i] = (nib(guess_m, i) == nib(secret_m, i));
    if (guess_m == secret_m) m_won = 1;
    else if (m_att == MT) m_lost = 1;
  endtask

  // Hold the button(s) long enough to be consumed, then release and let the sync settle.
  task automatic press(input bit s, input bit e, input logic [3:0] d);
    guess_digit = d;
    start_btn   = s;
    enter_btn   = e;
    tick();
    tick();
    if (s) secret_m = lfsr_m;
    tick();
    start_btn = 0;
    enter_btn = 0;
    if (s) begin
      in_game = 1; m_won = 0; m_lost = 0; m_att = 0; m_ptr = 0; m_hint = '0;
    end else if (e && in_game && !m_won && !m_lost) begin
      guess_m = (guess_m & ~(16'h000F << (4 * m_ptr))) | ({12'h000, d} << (4 * m_ptr));
      m_ptr++;
      if (m_ptr == CD) model_guess_done();
    end
    tick();
    tick();
    tick();
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < CD; i++) press(0, 1, nib(code, i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] g;
    int n;

    // Reset state, then release.
    model_reset();
    tick(); tick(); tick();
    check_model("reset");
    resetb = 1;
    tick();
    check_model("post_reset");

    // Correct code on first attempt.
    press(1, 0, 4'h0);
    check_model("start");
    for (int i = 0; i < CD; i++) begin
      press(0, 1, nib(secret_m, i));
      check_model("win_digit");
    end
    check("win", "breakcode_const", 32'(breakcode), 32'd1);
    check("win", "attempts_const",  32'(attempts),  32'd1);
    press(0, 1, 4'h5);
    check_model("won_enter_ignored");

    // Eight wrong guesses exhaust the tries.
    press(1, 0, 4'h0);
    for (int k = 0; k < MT; k++) begin
      g = 16'($urandom);
      if (g == secret_m) g = g ^ 16'h0001;
      enter_code(g);
      check_model("lose_guess");
    end
    check("lost", "gameover_const", 32'(gameover), 32'd1);
    check("lost", "attempts_const", 32'(attempts), 32'd8);
    press(0, 1, 4'h3);
    check_model("lost_enter_ignored");

    // Start and enter together after two digits: start wins.
    press(1, 0, 4'h0);
    press(0, 1, 4'($urandom));
    press(0, 1, 4'($urandom));
    check_model("two_digits");
    press(1, 1, 4'($urandom));
    check_model("start_enter_same");
    check("start_enter_same", "ptr_const", 32'(digit_ptr), 32'd0);
    enter_code(secret_m);
    check_model("after_same_win");

    // Digits 0 and 2 correct only.
    press(1, 0, 4'h0);
    enter_code(secret_m ^ 16'h1010);
    check_model("hint_0101");
`ifdef CODE_HINT_EN
    check("hint_0101", "hint_const", 32'(dut_hint), 32'h5);
`else
    check("hint_0101", "hint_const", 32'(dut_hint), 32'h0);
`endif

    // Randomized games: each digit independently right or random.
    for (int gm = 0; gm < 4; gm++) begin
      press(1, 0, 4'h0);
      n = 0;
      while (n < 3 && !m_won) begin
        for (int i = 0; i < CD; i++) begin
          logic [3:0] d;
          d = ($urandom_range(0, 2) != 0) ? nib(secret_m, i) : 4'($urandom);
          press(0, 1, d);
        end
        check_model("rand_game");
        n++;
      end
    end

    // Asynchronous reset mid-entry.
    press(1, 0, 4'h0);
    press(0, 1, nib(secret_m, 0));
    press(0, 1, nib(secret_m, 1));
    check_model("mid_entry");
    resetb = 0;
    #2;
    model_reset();
    check_model("async_reset");
    tick();
    resetb = 1;
    tick();
    check_model("reset_release_again");
    press(1, 0, 4'h0);
    enter_code(secret_m);
    check_model("win_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/code_entry_fsm.md
CODE_ENTRY_FSM -- requirements
Module: code_entry_fsm

Interface
- REQ-001 SHALL have parameter CODE_DIGITS, default 4, number of nibbles in the secret code.
- REQ-002 SHALL have parameter DIGIT_W, default 4, width of one code digit.
- REQ-003 SHALL have parameter MAX_TRIES, default 8, number of wrong guesses allowed before game over.
- REQ-004 SHALL have port clk, input, 1, system clock (100 MHz).
- REQ-005 SHALL have port resetb, input, 1, reset: asynchronous, active-low.
- REQ-006 SHALL have port start_btn, input, 1, asynchronous level from the start push-button (debounced externally).
- REQ-007 SHALL have port enter_btn, input, 1, asynchronous level from the enter push-button (debounced externally).
- REQ-008 SHALL have port guess_digit, input, DIGIT_W, switch value for the digit being entered.
- REQ-009 SHALL have port startgame, output, 1, game active; feeds the LED driver.
- REQ-010 SHALL have port breakcode, output, 1, code broken; feeds the LED driver.
- REQ-011 SHALL have port gameover, output, 1, tries exhausted.
- REQ-012 SHALL have port attempts, output, $clog2(MAX_TRIES+1), guesses evaluated.
- REQ-013 SHALL have port digit_ptr, output, $clog2(CODE_DIGITS), index of the next digit to enter.
- REQ-014 SHALL have port hint, output, CODE_DIGITS, per-digit match mask.

Function
- REQ-015 SHALL pass start_btn and enter_btn through a 2-flop synchronizer plus a rising-edge detector; registered outputs react at the 3rd clk edge after the input is first sampled high.
- REQ-016 SHALL run a free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 out of reset, advancing every cycle.
- REQ-017 SHALL use states IDLE, ENTER, CHECK, WON and LOST.
- REQ-018 SHALL, on a start pulse in any state: capture the LFSR into secret, clear attempts, digit_ptr and hint, and go to ENTER.
- REQ-019 SHALL, on an enter pulse in ENTER: store guess_digit into guess slot digit_ptr and increment digit_ptr; on the last slot, go to CHECK and reset digit_ptr to 0.
- REQ-020 SHALL spend exactly one cycle in CHECK: increment attempts, compare guess with secret, go to WON on match, to LOST when attempts reaches MAX_TRIES, else to ENTER.
- REQ-021 SHALL ignore enter pulses in IDLE, CHECK, WON and LOST.
- REQ-022 SHALL give a start pulse priority when start and enter pulse in the same cycle.
- REQ-023 SHALL drive startgame=1 in ENTER/CHECK/WON/LOST, breakcode=1 only in WON, and gameover=1 only in LOST; all outputs registered.
- REQ-024 SHALL saturate attempts at MAX_TRIES and never wrap.

Reset
- REQ-025 SHALL, while resetb=0, asynchronously force state=IDLE, LFSR=16'hACE1, secret/guess=0, all outputs 0 and synchronizer flops 0.
- REQ-026 SHALL abandon any game in progress when reset is asserted mid-operation, with no residual state.

Configuration
- REQ-027 SHALL, with CODE_HINT_EN defined, register hint in CHECK with bit i = (guess digit i == secret digit i), held until the next CHECK or start.
- REQ-028 SHALL, without CODE_HINT_EN, tie hint to 0 and build no comparator-mask register.

Structure
- REQ-029 SHALL place in package code_game_pkg: the state enum type, LFSR_SEED, LFSR_TAPS and default parameter constants.
- REQ-030 SHALL instantiate sub-module btn_sync_edge (2-flop sync + rising-edge pulse) once per button.

Verification
- REQ-031 SHALL cover: reset release -> startgame=breakcode=gameover=0, attempts=0, digit_ptr=0.
- REQ-032 SHALL cover: start, then the 4 correct digits (bench LFSR model) -> breakcode=1, startgame=1, attempts=1.
- REQ-033 SHALL cover: 8 wrong guesses -> gameover=1, attempts=8, breakcode=0; a further enter changes nothing.
- REQ-034 SHALL cover: start and enter pulsed together after 2 digits -> digit_ptr=0, attempts=0, state ENTER.
- REQ-035 SHALL cover: guess matching only digits 0 and 2 -> hint=4'b0101 with CODE_HINT_EN, 4'b0000 without.
- REQ-036 SHALL cover: resetb low mid-entry (digit_ptr=2) -> all outputs 0 immediately, without waiting for a clock.
